// File: rtl/fsb_pkg.sv
// Shared types and default timing constants for the FSB termination controller.
package fsb_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_ACK  = 3'd2,
      S_VPA  = 3'd3,
      S_ERR  = 3'd4
   } fsb_state_t;

   localparam int NCH_DEF     = 3;
   localparam int REF_DIV_DEF = 390;
   localparam int URG_DIV_DEF = 64;
   localparam int TO_CYC_DEF  = 255;

endpackage

// File: rtl/ref_timer.sv
// Refresh request generator: a free-running divider raises RefReq, and a
// request left pending for URG_DIV cycles escalates to RefUrgent.
module ref_timer
   import fsb_pkg::*;
#(
   parameter int REF_DIV = REF_DIV_DEF,
   parameter int URG_DIV = URG_DIV_DEF
) (
   input  logic CLK_FSB,
   input  logic RES,
   input  logic RefAck,
   output logic RefReq,
   output logic RefUrgent
);

   if (REF_DIV < 2) begin : g_bad_ref_div
      $error("ref_timer: REF_DIV must be at least 2");
   end
   if (URG_DIV < 2) begin : g_bad_urg_div
      $error("ref_timer: URG_DIV must be at least 2");
   end

   localparam int REF_W = $clog2(REF_DIV);
   localparam int URG_W = $clog2(URG_DIV);
   localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REF_DIV - 1);
   localparam logic [URG_W-1:0] URG_LAST = URG_W'(URG_DIV - 1);

   logic [REF_W-1:0] r_ref_cnt;
   logic [URG_W-1:0] r_urg_cnt;
   logic             r_ref_req;
   logic             r_ref_urgent;
   logic             w_tick;

   assign w_tick = (r_ref_cnt == '0);

   always_ff @(posedge CLK_FSB) begin
      if (RES) begin
         r_ref_cnt <= REF_LOAD;
      end else if (w_tick) begin
         r_ref_cnt <= REF_LOAD;
      end else begin
         r_ref_cnt <= r_ref_cnt - 1'b1;
      end
   end

   // A tick wins over RefAck so a fresh request is never lost.
   always_ff @(posedge CLK_FSB) begin
      if (RES) begin
         r_ref_req <= 1'b0;
      end else if (w_tick) begin
         r_ref_req <= 1'b1;
      end else if (RefAck) begin
         r_ref_req <= 1'b0;
      end
   end

   always_ff @(posedge CLK_FSB) begin
      if (RES || RefAck) begin
         r_urg_cnt    <= '0;
         r_ref_urgent <= 1'b0;
      end else if (r_ref_req && !r_ref_urgent) begin
         if (r_urg_cnt == URG_LAST) begin
            r_ref_urgent <= 1'b1;
         end else begin
            r_urg_cnt <= r_urg_cnt + 1'b1;
         end
      end
   end

   assign RefReq    = r_ref_req;
   assign RefUrgent = r_ref_urgent;

endmodule

// File: rtl/fsb_ack_ctrl.sv
// CPU bus-cycle terminator: picks DTACK, VPA or BERR for each strobe and
// holds it until the strobe negates. Optional WAIT timeout: FSB_TIMEOUT_EN.
module fsb_ack_ctrl
   import fsb_pkg::*;
#(
   parameter int NCH     = NCH_DEF,
   parameter int REF_DIV = REF_DIV_DEF,
   parameter int URG_DIV = URG_DIV_DEF,
   parameter int TO_CYC  = TO_CYC_DEF
) (
   input  logic           CLK_FSB,
   input  logic           RES,
   input  logic           nAS_FSB,
   input  logic [NCH-1:0] CS,
   input  logic [NCH-1:0] RDY,
   input  logic           IACS,
   input  logic           BERR_IN,
   input  logic           RefAck,
   output logic           ASActive,
   output logic           ASInactive,
   output logic           nDTACK_FSB,
   output logic           nVPA_FSB,
   output logic           nBERR_FSB,
   output logic           RefReq,
   output logic           RefUrgent,
   output fsb_state_t     o_dbg_state
);

   if (TO_CYC < 2) begin : g_bad_to_cyc
      $error("fsb_ack_ctrl: TO_CYC must be at least 2");
   end
   if (NCH < 1) begin : g_bad_nch
      $error("fsb_ack_ctrl: NCH must be at least 1");
   end

   fsb_state_t r_state;
   fsb_state_t w_state_next;
   logic       r_as_active;
   logic       r_as_inactive;
   logic       r_ndtack;
   logic       r_nvpa;
   logic       r_nberr;
   logic       w_ref_urgent;
   logic       w_dtack_ok;
   logic       w_timeout;

   ref_timer #(
      .REF_DIV (REF_DIV),
      .URG_DIV (URG_DIV)
   ) u_ref_timer (
      .CLK_FSB   (CLK_FSB),
      .RES       (RES),
      .RefAck    (RefAck),
      .RefReq    (RefReq),
      .RefUrgent (w_ref_urgent)
   );

   always_ff @(posedge CLK_FSB) begin
      if (RES) begin
         r_as_active   <= 1'b0;
         r_as_inactive <= 1'b1;
      end else begin
         r_as_active   <= ~nAS_FSB;
         r_as_inactive <= nAS_FSB;
      end
   end

   // Every selected channel must be ready; urgent refresh holds off RAM-style acks.
   assign w_dtack_ok = (|CS) && (&(RDY | ~CS)) && !w_ref_urgent;

`ifdef FSB_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYC);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

   logic [TO_W-1:0] r_to_cnt;

   always_ff @(posedge CLK_FSB) begin
      if (RES) begin
         r_to_cnt <= '0;
      end else if (r_state == S_WAIT && w_state_next == S_WAIT) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
         r_to_cnt <= '0;
      end
   end

   assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == TO_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge CLK_FSB) begin
      if (RES) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (r_as_active) w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (r_as_inactive)   w_state_next = S_IDLE;
            else if (IACS)       w_state_next = S_VPA;
            else if (BERR_IN)    w_state_next = S_ERR;
            else if (w_timeout)  w_state_next = S_ERR;
            else if (w_dtack_ok) w_state_next = S_ACK;
         end
         S_ACK, S_VPA, S_ERR: begin
            if (r_as_inactive) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // A termination is low only while its state persists, so leaving the state
   // negates it on the same edge that returns the FSM to IDLE.
   always_ff @(posedge CLK_FSB) begin
      if (RES) begin
         r_ndtack <= 1'b1;
         r_nvpa   <= 1'b1;
         r_nberr  <= 1'b1;
      end else begin
         r_ndtack <= !(r_state == S_ACK && w_state_next == S_ACK);
         r_nvpa   <= !(r_state == S_VPA && w_state_next == S_VPA);
         r_nberr  <= !(r_state == S_ERR && w_state_next == S_ERR);
      end
   end

   assign ASActive    = r_as_active;
   assign ASInactive  = r_as_inactive;
   assign nDTACK_FSB  = r_ndtack;
   assign nVPA_FSB    = r_nvpa;
   assign nBERR_FSB   = r_nberr;
   assign RefUrgent   = w_ref_urgent;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fsb_ack_ctrl.sv
// Directed bench for fsb_ack_ctrl: table of access vectors plus hand-written
// refresh, timeout and reset sequences.
module tb_fsb_ack_ctrl;
   import fsb_pkg::*;

   localparam int NCH = 3;

   logic           clk;
   logic           res;
   logic           nas;
   logic [NCH-1:0] cs;
   logic [NCH-1:0] rdy;
   logic           iacs;
   logic           berr_in;
   logic           ref_ack;
   logic           as_active;
   logic           as_inactive;
   logic           ndtack;
   logic           nvpa;
   logic           nberr;
   logic           ref_req;
   logic           ref_urgent;
   fsb_state_t     dbg_state;

   int checks = 0;
   int errors = 0;
   logic [2:0] exp_q[$];

   fsb_ack_ctrl #(
      .NCH     (NCH),
      .REF_DIV (10),
      .URG_DIV (4),
      .TO_CYC  (8)
   ) dut (
      .CLK_FSB     (clk),
      .RES         (res),
      .nAS_FSB     (nas),
      .CS          (cs),
      .RDY         (rdy),
      .IACS        (iacs),
      .BERR_IN     (berr_in),
      .RefAck      (ref_ack),
      .ASActive    (as_active),
      .ASInactive  (as_inactive),
      .nDTACK_FSB  (ndtack),
      .nVPA_FSB    (nvpa),
      .nBERR_FSB   (nberr),
      .RefReq      (ref_req),
      .RefUrgent   (ref_urgent),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] cs;
      logic [2:0] rdy;
      logic       iacs;
      logic       berr;
      logic [2:0] exp_term;  // {nDTACK, nVPA, nBERR} while the strobe is held
   } vec_t;

   localparam logic [2:0] T_DTACK = 3'b011;
   localparam logic [2:0] T_VPA   = 3'b101;
   localparam logic [2:0] T_BERR  = 3'b110;
   localparam logic [2:0] T_NONE  = 3'b111;

   vec_t vecs[10];

   // driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      res = 1'b1;
      tick(1);
      res = 1'b0;
   endtask

   task automatic clear_inputs();
      nas     = 1'b1;
      cs      = '0;
      rdy     = '0;
      iacs    = 1'b0;
      berr_in = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] terms();
      return {ndtack, nvpa, nberr};
   endfunction

   logic seen_berr;

   initial begin
      clear_inputs();
      res     = 1'b1;
      ref_ack = 1'b0;
      tick(2);
      check("reset_terms",  32'(terms()), 32'(T_NONE));
      check("reset_asact",  32'(as_active), 32'd0);
      check("reset_asinac", 32'(as_inactive), 32'd1);
      check("reset_refreq", 32'(ref_req), 32'd0);
      check("reset_urgent", 32'(ref_urgent), 32'd0);
      check("reset_state",  32'(dbg_state), 32'(S_IDLE));
      res = 1'b0;

      // refresh request, urgency, and an access held off by urgency
      do_reset();
      tick(9);
      check("ref_req_c9", 32'(ref_req), 32'd0);
      tick(1);
      check("ref_req_c10", 32'(ref_req), 32'd1);
      check("urg_c10", 32'(ref_urgent), 32'd0);
      tick(3);
      check("urg_c13", 32'(ref_urgent), 32'd0);
      tick(1);
      check("urg_c14", 32'(ref_urgent), 32'd1);
      tick(2);
      nas = 1'b0; cs = 3'b001; rdy = 3'b111;
      tick(1);
      check("ref_acc_asact", 32'(as_active), 32'd1);
      tick(5);
      check("ref_acc_wait", 32'(dbg_state), 32'(S_WAIT));
      check("ref_acc_nodtack", 32'(ndtack), 32'd1);
      check("ref_acc_urg_kept", 32'(ref_urgent), 32'd1);
      check("ref_acc_req_kept", 32'(ref_req), 32'd1);
      ref_ack = 1'b1;
      tick(1);
      ref_ack = 1'b0;
      check("ref_ack_req_clr", 32'(ref_req), 32'd0);
      check("ref_ack_urg_clr", 32'(ref_urgent), 32'd0);
      tick(1);
      check("ref_acc_ack_state", 32'(dbg_state), 32'(S_ACK));
      tick(1);
      check("ref_acc_dtack", 32'(terms()), 32'(T_DTACK));
      clear_inputs();
      tick(2);
      check("ref_acc_release", 32'(terms()), 32'(T_NONE));

      // refresh tick coinciding with RefAck
      do_reset();
      tick(19);
      check("coin_urg_before", 32'(ref_urgent), 32'd1);
      ref_ack = 1'b1;
      tick(1);
      ref_ack = 1'b0;
      check("coin_req_kept", 32'(ref_req), 32'd1);
      check("coin_urg_clr", 32'(ref_urgent), 32'd0);
      tick(3);
      check("coin_urg_c23", 32'(ref_urgent), 32'd0);
      tick(1);
      check("coin_urg_c24", 32'(ref_urgent), 32'd1);

      // hold RefAck so urgency never builds during the access table
      ref_ack = 1'b1;
      do_reset();

      vecs[0] = '{cs: 3'b001, rdy: 3'b001, iacs: 1'b0, berr: 1'b0, exp_term: T_DTACK};
      vecs[1] = '{cs: 3'b010, rdy: 3'b010, iacs: 1'b0, berr: 1'b0, exp_term: T_DTACK};
      vecs[2] = '{cs: 3'b101, rdy: 3'b101, iacs: 1'b0, berr: 1'b0, exp_term: T_DTACK};
      vecs[3] = '{cs: 3'b011, rdy: 3'b001, iacs: 1'b0, berr: 1'b0, exp_term: T_NONE};
      vecs[4] = '{cs: 3'b001, rdy: 3'b001, iacs: 1'b1, berr: 1'b1, exp_term: T_VPA};
      vecs[5] = '{cs: 3'b001, rdy: 3'b001, iacs: 1'b0, berr: 1'b1, exp_term: T_BERR};
      vecs[6] = '{cs: 3'b000, rdy: 3'b111, iacs: 1'b0, berr: 1'b0, exp_term: T_NONE};
      vecs[7] = '{cs: 3'b111, rdy: 3'b110, iacs: 1'b0, berr: 1'b0, exp_term: T_NONE};
      vecs[8] = '{cs: 3'b000, rdy: 3'b000, iacs: 1'b1, berr: 1'b0, exp_term: T_VPA};
      vecs[9] = '{cs: 3'b100, rdy: 3'b111, iacs: 1'b0, berr: 1'b0, exp_term: T_DTACK};

      foreach (vecs[i]) exp_q.push_back(vecs[i].exp_term);

      for (int i = 0; i < 10; i++) begin
         logic [2:0] exp_t;
         exp_t   = exp_q.pop_front();
         cs      = vecs[i].cs;
         rdy     = vecs[i].rdy;
         iacs    = vecs[i].iacs;
         berr_in = vecs[i].berr;
         nas     = 1'b0;
         tick(4);
         check($sformatf("vec%0d_assert", i), 32'(terms()), 32'(exp_t));
         tick(2);
         check($sformatf("vec%0d_hold", i), 32'(terms()), 32'(exp_t));
         nas = 1'b1;
         tick(1);
         check($sformatf("vec%0d_hold_asinac", i), 32'(terms()), 32'(exp_t));
         tick(1);
         check($sformatf("vec%0d_release", i), 32'(terms()), 32'(T_NONE));
         check($sformatf("vec%0d_idle", i), 32'(dbg_state), 32'(S_IDLE));
         clear_inputs();
         tick(1);
      end

      // RDY[0] arrives four cycles after ASActive
      cs = 3'b001; rdy = 3'b000; nas = 1'b0;
      tick(1);
      check("late_asact", 32'(as_active), 32'd1);
      tick(4);
      check("late_not_ready", 32'(ndtack), 32'd1);
      rdy = 3'b001;
      tick(1);
      check("late_ack_state", 32'(ndtack), 32'd1);
      tick(1);
      check("late_dtack", 32'(ndtack), 32'd0);
      nas = 1'b1;
      tick(1);
      check("late_dtack_hold", 32'(ndtack), 32'd0);
      tick(1);
      check("late_dtack_neg", 32'(ndtack), 32'd1);
      clear_inputs();
      tick(1);

      // nothing selected: timeout build errors out, default build waits
      nas = 1'b0;
`ifdef FSB_TIMEOUT_EN
      tick(10);
      check("to_err_state", 32'(dbg_state), 32'(S_ERR));
      check("to_berr_not_yet", 32'(nberr), 32'd1);
      tick(1);
      check("to_berr", 32'(terms()), 32'(T_BERR));
`else
      seen_berr = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         tick(1);
         if (!nberr) seen_berr = 1'b1;
      end
      check("no_to_berr", 32'(seen_berr), 32'd0);
      check("no_to_wait", 32'(dbg_state), 32'(S_WAIT));
`endif
      nas = 1'b1;
      tick(2);
      check("to_release", 32'(terms()), 32'(T_NONE));
      tick(1);

      // reset while DTACK is asserted
      cs = 3'b001; rdy = 3'b001; nas = 1'b0;
      tick(4);
      check("rst_mid_dtack", 32'(ndtack), 32'd0);
      res = 1'b1;
      tick(1);
      res = 1'b0;
      check("rst_mid_terms",  32'(terms()), 32'(T_NONE));
      check("rst_mid_asact",  32'(as_active), 32'd0);
      check("rst_mid_asinac", 32'(as_inactive), 32'd1);
      check("rst_mid_refreq", 32'(ref_req), 32'd0);
      check("rst_mid_urgent", 32'(ref_urgent), 32'd0);
      check("rst_mid_state",  32'(dbg_state), 32'(S_IDLE));
      clear_inputs();
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
